max7219_rx_decoder: RTL

Synthesizable receiver for the MAX7219 serial protocol (LOAD/DIN/CLK) driven by `max7219_if`. It oversamples the three serial lines in the system clock domain and deserializes a daisy-chain of `G_NB_MATRIX` 16-bit frames. On each LOAD rising edge it emits one decoded (matrix, address, data) frame per cycle and, optionally, maintains a per-matrix register image. It sits on the far end of the `max7219_scroller_ctrl` → `max7219_if` chain, as an RTL loopback and monitor.

---
 rtl/max7219_rx_pkg.sv | 27 ++
 rtl/max7219_rx_sync.sv | 32 +++
 rtl/max7219_rx_decoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/max7219_rx_pkg.sv
// Shared types and constants for the MAX7219 serial receiver/decoder.
package max7219_rx_pkg;

  localparam logic [3:0] C_ADDR_NOOP       = 4'h0;
  localparam logic [3:0] C_ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] C_ADDR_DECODE     = 4'h9;
  localparam logic [3:0] C_ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] C_ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] C_ADDR_SHUTDOWN   = 4'hC;
  localparam logic [3:0] C_ADDR_TEST       = 4'hF;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } t_max7219_frame;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } t_rx_state;

  // Addresses backed by a real device register (no-op and reserved excluded).
  function automatic logic is_image_addr(input logic [3:0] addr);
    return ((addr >= C_ADDR_DIGIT0) && (addr <= C_ADDR_SHUTDOWN)) || (addr == C_ADDR_TEST);
  endfunction

endpackage

// File: rtl/max7219_rx_sync.sv
// Two-flop synchronizer with a rising-edge detect register for one serial line.
module max7219_rx_sync
  import max7219_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus the previous-level register used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;

endmodule

// File: rtl/max7219_rx_decoder.sv
// MAX7219 LOAD/DIN/CLK receiver: deserializes a daisy chain and emits one frame per cycle.
// Optional per-matrix register image enabled by macro MAX7219_RX_REGFILE_EN.
module max7219_rx_decoder
  import max7219_rx_pkg::*;
#(
  parameter int G_NB_MATRIX        = 8,
  parameter int G_MATRIX_IDX_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_max7219_clk,
  input  logic                          i_max7219_din,
  input  logic                          i_max7219_load,
  output logic                          o_valid,
  output logic [G_MATRIX_IDX_WIDTH-1:0] o_matrix_idx,
  output logic [3:0]                    o_addr,
  output logic [7:0]                    o_data,
  output logic                          o_err_len,
  output logic                          o_overrun,
  input  logic [G_MATRIX_IDX_WIDTH-1:0] i_rd_matrix,
  input  logic [3:0]                    i_rd_addr,
  output logic [7:0]                    o_rd_data
);

  localparam int C_SR_W = 16 * G_NB_MATRIX;
  localparam int C_CNT_W = $clog2(C_SR_W) + 1;
  localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(C_SR_W);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = {C_CNT_W{1'b1}};
  localparam logic [G_MATRIX_IDX_WIDTH-1:0] C_IDX_LAST = G_MATRIX_IDX_WIDTH'(G_NB_MATRIX - 1);
  localparam logic [G_MATRIX_IDX_WIDTH-1:0] C_IDX_ZERO = {G_MATRIX_IDX_WIDTH{1'b0}};

  logic din_level_s;
  logic sclk_rise_s;
  logic load_rise_s;
  logic unused_din_rise_s;
  logic unused_sclk_level_s;
  logic unused_load_level_s;

  logic [C_SR_W-1:0]             shift_r;
  logic [C_CNT_W-1:0]            cnt_r;
  logic [15:0]                   frame_buf_r [G_NB_MATRIX];
  t_rx_state                     state_r;
  t_rx_state                     state_nxt_s;
  logic [G_MATRIX_IDX_WIDTH-1:0] idx_r;
  logic [G_MATRIX_IDX_WIDTH-1:0] idx_nxt_s;
  logic                          accept_s;
  logic                          emit_s;
  logic                          err_nxt_s;
  logic                          ovr_nxt_s;
  logic [15:0]                   cur_word_s;
  logic [3:0]                    unused_frame_hi_s;
  t_max7219_frame                cur_frame_s;

  max7219_rx_sync u_sync_clk (
    .clk(clk), .rst_n(rst_n), .async_in(i_max7219_clk),
    .level(unused_sclk_level_s), .rise(sclk_rise_s)
  );

  max7219_rx_sync u_sync_din (
    .clk(clk), .rst_n(rst_n), .async_in(i_max7219_din),
    .level(din_level_s), .rise(unused_din_rise_s)
  );

  max7219_rx_sync u_sync_load (
    .clk(clk), .rst_n(rst_n), .async_in(i_max7219_load),
    .level(unused_load_level_s), .rise(load_rise_s)
  );

  // Shift register and saturating bit counter; any LOAD edge restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {C_SR_W{1'b0}};
      cnt_r   <= {C_CNT_W{1'b0}};
    end else begin
      if (sclk_rise_s) begin
        shift_r <= {shift_r[C_SR_W-2:0], din_level_s};
      end
      if (load_rise_s) begin
        cnt_r <= {C_CNT_W{1'b0}};
      end else if (sclk_rise_s && (cnt_r != C_CNT_MAX)) begin
        cnt_r <= cnt_r + C_CNT_W'(1);
      end
    end
  end

  // Snapshot the whole chain so shifting can resume while frames drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < G_NB_MATRIX; k++) frame_buf_r[k] <= 16'h0000;
    end else if (accept_s) begin
      for (int k = 0; k < G_NB_MATRIX; k++) frame_buf_r[k] <= shift_r[16*k +: 16];
    end
  end

  // FSM state and emission index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= C_IDX_ZERO;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state logic: accept or reject LOAD in IDLE, flag overrun in EMIT.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    accept_s    = 1'b0;
    emit_s      = 1'b0;
    err_nxt_s   = 1'b0;
    ovr_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_rise_s) begin
          if (cnt_r == C_CNT_FULL) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_EMIT;
            idx_nxt_s   = C_IDX_ZERO;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        emit_s    = 1'b1;
        ovr_nxt_s = load_rise_s;
        if (idx_r == C_IDX_LAST) begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = C_IDX_ZERO;
        end else begin
          idx_nxt_s = idx_r + G_MATRIX_IDX_WIDTH'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = C_IDX_ZERO;
      end
    endcase
  end

  assign cur_word_s        = frame_buf_r[idx_r];
  assign cur_frame_s       = t_max7219_frame'(cur_word_s[11:0]);
  assign unused_frame_hi_s = cur_word_s[15:12];

  // Registered frame stream; addr/data/idx hold the last frame between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid      <= 1'b0;
      o_matrix_idx <= C_IDX_ZERO;
      o_addr       <= 4'h0;
      o_data       <= 8'h00;
      o_err_len    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_valid   <= emit_s;
      o_err_len <= err_nxt_s;
      o_overrun <= ovr_nxt_s;
      if (emit_s) begin
        o_matrix_idx <= idx_r;
        o_addr       <= cur_frame_s.addr;
        o_data       <= cur_frame_s.data;
      end
    end
  end

`ifdef MAX7219_RX_REGFILE_EN
  logic [7:0] image_r [G_NB_MATRIX][16];

  // Register image written as frames are emitted; no-op and reserved are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < G_NB_MATRIX; m++) begin
        for (int a = 0; a < 16; a++) image_r[m][a] <= 8'h00;
      end
    end else if (emit_s && is_image_addr(cur_frame_s.addr)) begin
      image_r[idx_r][cur_frame_s.addr] <= cur_frame_s.data;
    end
  end

  // Registered read port; a same-cycle write is seen only on the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_data <= 8'h00;
    end else if (is_image_addr(i_rd_addr) && (i_rd_matrix <= C_IDX_LAST)) begin
      o_rd_data <= image_r[i_rd_matrix][i_rd_addr];
    end else begin
      o_rd_data <= 8'h00;
    end
  end
`else
  logic [G_MATRIX_IDX_WIDTH+3:0] unused_rd_s;
  assign unused_rd_s = {i_rd_matrix, i_rd_addr};

  // No image storage: read data is held at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_data <= 8'h00;
    end else begin
      o_rd_data <= 8'h00;
    end
  end
`endif

endmodule
